// File: rtl/seg7_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// seg7_pkg
// Shared seven-segment pattern constants (active-low gfedcba) and helpers
// used by the capture monitor and the display self-test.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
package seg7_pkg;

  // Active-low gfedcba patterns for hex digits 0..F
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_A     = 7'h08;
  localparam logic [6:0] SEG_B     = 7'h03;
  localparam logic [6:0] SEG_C     = 7'h46;
  localparam logic [6:0] SEG_D     = 7'h21;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_F     = 7'h0E;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Decimal point lives in bit 7 of the segment bus; segments are lit low
  localparam int   SEG_DP = 7;
  localparam logic SEG_ON = 1'b0;

  // Forward encode, the inverse of the capture decoder
  function automatic logic [6:0] seg_encode(input logic [3:0] hex);
    logic [6:0] pat;
    case (hex)
      4'h0:    pat = SEG_0;
      4'h1:    pat = SEG_1;
      4'h2:    pat = SEG_2;
      4'h3:    pat = SEG_3;
      4'h4:    pat = SEG_4;
      4'h5:    pat = SEG_5;
      4'h6:    pat = SEG_6;
      4'h7:    pat = SEG_7;
      4'h8:    pat = SEG_8;
      4'h9:    pat = SEG_9;
      4'hA:    pat = SEG_A;
      4'hB:    pat = SEG_B;
      4'hC:    pat = SEG_C;
      4'hD:    pat = SEG_D;
      4'hE:    pat = SEG_E;
      default: pat = SEG_F;
    endcase
    return pat;
  endfunction

endpackage : seg7_pkg
`default_nettype wire

// File: rtl/seg7_pattern_decode.sv
`default_nettype none
// ---------------------------------------------------------------------------
// seg7_pattern_decode
// Combinational 7-bit active-low segment pattern to {hit, hex, blank}.
// hit   : pattern is one of the sixteen hex glyphs
// blank : pattern has every segment dark
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [6:0] pattern,
  output logic       hit,
  output logic [3:0] hex,
  output logic       blank
);

  // Glyph lookup; anything outside the table reports a miss with hex 0
  always_comb begin
    hit = 1'b1;
    hex = 4'h0;
    case (pattern)
      SEG_0:   hex = 4'h0;
      SEG_1:   hex = 4'h1;
      SEG_2:   hex = 4'h2;
      SEG_3:   hex = 4'h3;
      SEG_4:   hex = 4'h4;
      SEG_5:   hex = 4'h5;
      SEG_6:   hex = 4'h6;
      SEG_7:   hex = 4'h7;
      SEG_8:   hex = 4'h8;
      SEG_9:   hex = 4'h9;
      SEG_A:   hex = 4'hA;
      SEG_B:   hex = 4'hB;
      SEG_C:   hex = 4'hC;
      SEG_D:   hex = 4'hD;
      SEG_E:   hex = 4'hE;
      SEG_F:   hex = 4'hF;
      default: begin
        hit = 1'b0;
        hex = 4'h0;
      end
    endcase
  end

  assign blank = (pattern == SEG_BLANK);

endmodule : seg7_pattern_decode
`default_nettype wire

// File: rtl/seg7_scan_capture.sv
`default_nettype none
// ---------------------------------------------------------------------------
// seg7_scan_capture
// Receive-side monitor for a multiplexed seven-segment bus. Samples the
// segment lines and active-low digit enables, waits for STABLE_CNT identical
// qualifying samples, then decodes the glyph back to hex + DP per digit.
// Build option: SEG7_SCAN_CAPTURE_BLANK_EN - an all-dark glyph commits as a
// blank digit (clears DigitValid) instead of raising Err.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
module seg7_scan_capture
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int STABLE_CNT = 4
) (
  input  logic                    Clk,
  input  logic                    nRst,
  input  logic [7:0]              SSeg,
  input  logic [NUM_DIGITS-1:0]   An,
  input  logic                    ErrClr,
  output logic [4*NUM_DIGITS-1:0] HexOut,
  output logic [NUM_DIGITS-1:0]   DPOut,
  output logic [NUM_DIGITS-1:0]   DigitValid,
  output logic                    Update,
  output logic [2:0]              UpdIdx,
  output logic                    Err
);

  localparam int             CNT_W   = $clog2(STABLE_CNT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CNT);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

`ifdef SEG7_SCAN_CAPTURE_BLANK_EN
  localparam logic BLANK_EN = 1'b1;
`else
  localparam logic BLANK_EN = 1'b0;
`endif

  // Sample stage
  logic [7:0]            sseg_s_q, sseg_s_d;
  logic [NUM_DIGITS-1:0] an_s_q, an_s_d;

  // Stability tracking
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       ref_seg_q, ref_seg_d;
  logic [2:0]       ref_idx_q, ref_idx_d;

  // Committed outputs
  logic [4*NUM_DIGITS-1:0] hex_q, hex_d;
  logic [NUM_DIGITS-1:0]   dp_q, dp_d;
  logic [NUM_DIGITS-1:0]   valid_q, valid_d;
  logic                    upd_q, upd_d;
  logic [2:0]              upd_idx_q, upd_idx_d;
  logic                    err_q, err_d;

  // Combinational helpers
  logic [3:0] low_cnt;
  logic [2:0] sel_idx;
  logic       qual;
  logic       same;
  logic       commit;
  logic       dec_hit;
  logic [3:0] dec_hex;
  logic       dec_blank;
  logic       blank_ok;

  assign sseg_s_d = SSeg;
  assign an_s_d   = An;

  // One-hot check of the sampled enables and encode of the selected digit
  always_comb begin
    low_cnt = 4'd0;
    sel_idx = 3'd0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (an_s_q[i] == 1'b0) begin
        low_cnt = low_cnt + 4'd1;
        sel_idx = 3'(i);
      end
    end
  end

  assign qual = (low_cnt == 4'd1);
  assign same = (sel_idx == ref_idx_q) && (sseg_s_q == ref_seg_q);

  seg7_pattern_decode u_decode (
    .pattern (sseg_s_q[6:0]),
    .hit     (dec_hit),
    .hex     (dec_hex),
    .blank   (dec_blank)
  );

  assign blank_ok = BLANK_EN & dec_blank;

  // Stability counter: restart on any new digit/pattern, saturate at the target
  always_comb begin
    cnt_d     = cnt_q;
    ref_seg_d = ref_seg_q;
    ref_idx_d = ref_idx_q;
    commit    = 1'b0;
    if (!qual) begin
      cnt_d = '0;
    end else if (same && (cnt_q != '0)) begin
      if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + CNT_ONE;
      end
      // Fires once, on the step that lands on the target
      commit = (cnt_q == (CNT_MAX - CNT_ONE));
    end else begin
      cnt_d     = CNT_ONE;
      ref_seg_d = sseg_s_q;
      ref_idx_d = sel_idx;
    end
  end

  // Commit a stable glyph into the per-digit readback registers or flag it
  always_comb begin
    hex_d     = hex_q;
    dp_d      = dp_q;
    valid_d   = valid_q;
    upd_d     = 1'b0;
    upd_idx_d = upd_idx_q;
    err_d     = err_q & ~ErrClr;
    if (commit) begin
      if (dec_hit || blank_ok) begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
          if (3'(i) == sel_idx) begin
            hex_d[4*i +: 4] = dec_hit ? dec_hex : 4'h0;
            dp_d[i]         = (sseg_s_q[SEG_DP] == SEG_ON);
            valid_d[i]      = dec_hit;
          end
        end
        upd_d     = 1'b1;
        upd_idx_d = sel_idx;
      end else begin
        // A new error outranks a simultaneous clear
        err_d = 1'b1;
      end
    end
  end

  // Input sample stage
  always_ff @(posedge Clk or negedge nRst) begin
    if (!nRst) begin
      sseg_s_q <= '0;
      an_s_q   <= '0;
    end else begin
      sseg_s_q <= sseg_s_d;
      an_s_q   <= an_s_d;
    end
  end

  // Stability tracking and committed output state
  always_ff @(posedge Clk or negedge nRst) begin
    if (!nRst) begin
      cnt_q     <= '0;
      ref_seg_q <= '0;
      ref_idx_q <= '0;
      hex_q     <= '0;
      dp_q      <= '0;
      valid_q   <= '0;
      upd_q     <= 1'b0;
      upd_idx_q <= '0;
      err_q     <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      ref_seg_q <= ref_seg_d;
      ref_idx_q <= ref_idx_d;
      hex_q     <= hex_d;
      dp_q      <= dp_d;
      valid_q   <= valid_d;
      upd_q     <= upd_d;
      upd_idx_q <= upd_idx_d;
      err_q     <= err_d;
    end
  end

  assign HexOut     = hex_q;
  assign DPOut      = dp_q;
  assign DigitValid = valid_q;
  assign Update     = upd_q;
  assign UpdIdx     = upd_idx_q;
  assign Err        = err_q;

endmodule : seg7_scan_capture
`default_nettype wire

// File: tb/tb_seg7_scan_capture.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_seg7_scan_capture
// Directed self-checking bench for seg7_scan_capture (NUM_DIGITS=4,
// STABLE_CNT=4). Honours SEG7_SCAN_CAPTURE_BLANK_EN when defined.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_seg7_scan_capture;

  logic        Clk = 1'b0;
  logic        nRst;
  logic [7:0]  SSeg;
  logic [3:0]  An;
  logic        ErrClr;
  logic [15:0] HexOut;
  logic [3:0]  DPOut;
  logic [3:0]  DigitValid;
  logic        Update;
  logic [2:0]  UpdIdx;
  logic        Err;

  int checks   = 0;
  int passed   = 0;
  int failed   = 0;
  int upd_cnt  = 0;
  int upd_base = 0;

  always #5 Clk = ~Clk;

  seg7_scan_capture #(
    .NUM_DIGITS (4),
    .STABLE_CNT (4)
  ) dut (
    .Clk        (Clk),
    .nRst       (nRst),
    .SSeg       (SSeg),
    .An         (An),
    .ErrClr     (ErrClr),
    .HexOut     (HexOut),
    .DPOut      (DPOut),
    .DigitValid (DigitValid),
    .Update     (Update),
    .UpdIdx     (UpdIdx),
    .Err        (Err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge and tally any Update pulse seen there
  task automatic tick();
    @(negedge Clk);
    if (Update === 1'b1) upd_cnt++;
  endtask

  initial begin
    // Reset with random inputs
    nRst   = 1'b0;
    ErrClr = 1'b0;
    An     = 4'hF;
    SSeg   = 8'hFF;
    repeat (5) begin
      An     = 4'($urandom);
      SSeg   = 8'($urandom);
      ErrClr = 1'($urandom);
      tick();
    end
    check("rst_hex",   HexOut, 16'h0000);
    check("rst_misc",  {DPOut, DigitValid, Update, UpdIdx, Err}, 13'h0);
    An     = 4'hF;
    SSeg   = 8'hFF;
    ErrClr = 1'b0;
    nRst   = 1'b1;
    repeat (3) tick();
    check("post_rst_hex",  HexOut, 16'h0000);
    check("post_rst_misc", {DPOut, DigitValid, Update, UpdIdx, Err}, 13'h0);
    check("post_rst_upd",  upd_cnt, 0);

    // Stable commit: digit 0, glyph 2, DP dark (bit 7 high)
    upd_base = upd_cnt;
    An   = 4'b1110;
    SSeg = 8'hA4;
    repeat (4) tick();
    check("a4_early", Update, 1'b0);
    tick();
    check("a4_pulse", Update, 1'b1);
    check("a4_idx",   UpdIdx, 3'd0);
    check("a4_hex",   HexOut[3:0], 4'h2);
    check("a4_dp",    DPOut[0], 1'b0);
    check("a4_valid", DigitValid, 4'b0001);
    tick();
    check("a4_pulse_end", Update, 1'b0);
    repeat (6) tick();
    check("a4_once", upd_cnt - upd_base, 1);

    // Glitch restart: '1' for 3 edges, then '3' -> only '3' commits
    upd_base = upd_cnt;
    An   = 4'b1101;
    SSeg = 8'hF9;
    repeat (3) tick();
    SSeg = 8'hB0;
    repeat (4) tick();
    check("glitch_early", upd_cnt - upd_base, 0);
    tick();
    check("glitch_pulse", Update, 1'b1);
    repeat (4) tick();
    check("glitch_once",  upd_cnt - upd_base, 1);
    check("glitch_idx",   UpdIdx, 3'd1);
    check("glitch_hex",   HexOut[7:4], 4'h3);
    check("glitch_dp",    DPOut[1], 1'b0);
    check("glitch_valid", DigitValid, 4'b0011);

    // Illegal enables: two low, then none low
    upd_base = upd_cnt;
    An   = 4'b1100;
    SSeg = 8'hC0;
    repeat (10) tick();
    An = 4'b1111;
    repeat (10) tick();
    check("illegal_upd",   upd_cnt - upd_base, 0);
    check("illegal_hex",   HexOut, 16'h0032);
    check("illegal_valid", DigitValid, 4'b0011);
    check("illegal_idx",   UpdIdx, 3'd1);

    // Interrupted run restarts; identical value recommits with a pulse
    upd_base = upd_cnt;
    An   = 4'b1110;
    SSeg = 8'hA4;
    repeat (3) tick();
    An = 4'b1111;
    repeat (2) tick();
    An = 4'b1110;
    repeat (4) tick();
    check("intr_early", upd_cnt - upd_base, 0);
    tick();
    check("intr_pulse", Update, 1'b1);
    check("intr_idx",   UpdIdx, 3'd0);
    repeat (3) tick();
    check("intr_once",  upd_cnt - upd_base, 1);

    // DP lit: digit 3, glyph 5, bit 7 low
    An   = 4'b0111;
    SSeg = 8'h12;
    repeat (5) tick();
    check("dp_pulse", Update, 1'b1);
    check("dp_hex",   HexOut[15:12], 4'h5);
    check("dp_lit",   DPOut[3], 1'b1);
    check("dp_idx",   UpdIdx, 3'd3);
    repeat (2) tick();

    // All-dark glyph on digit 2
    upd_base = upd_cnt;
    An   = 4'b1011;
    SSeg = 8'hFF;
    repeat (8) tick();
`ifdef SEG7_SCAN_CAPTURE_BLANK_EN
    check("blank_upd",   upd_cnt - upd_base, 1);
    check("blank_err",   Err, 1'b0);
    check("blank_idx",   UpdIdx, 3'd2);
    check("blank_hex",   HexOut[11:8], 4'h0);
    check("blank_dp",    DPOut[2], 1'b0);
`else
    check("blank_upd",   upd_cnt - upd_base, 0);
    check("blank_err",   Err, 1'b1);
    check("blank_idx",   UpdIdx, 3'd3);
`endif
    check("blank_valid", DigitValid, 4'b1011);

    // ErrClr alone clears
    An     = 4'b1111;
    ErrClr = 1'b1;
    tick();
    ErrClr = 1'b0;
    check("errclr", Err, 1'b0);

    // ErrClr in the same cycle as an error commit: set wins
    upd_base = upd_cnt;
    An   = 4'b1011;
    SSeg = 8'hFE;
    repeat (4) tick();
    check("err_pre", Err, 1'b0);
    ErrClr = 1'b1;
    tick();
    ErrClr = 1'b0;
    check("err_setwins", Err, 1'b1);
    repeat (3) tick();
    check("err_sticky", Err, 1'b1);
    check("err_noupd",  upd_cnt - upd_base, 0);
    ErrClr = 1'b1;
    tick();
    ErrClr = 1'b0;
    check("err_clr2", Err, 1'b0);

    // Scan sweep: 0, 9, A, F on digits 0..3
    upd_base = upd_cnt;
    An = 4'b1110; SSeg = 8'hC0; repeat (6) tick(); check("sweep_idx0", UpdIdx, 3'd0);
    An = 4'b1101; SSeg = 8'h90; repeat (6) tick(); check("sweep_idx1", UpdIdx, 3'd1);
    An = 4'b1011; SSeg = 8'h88; repeat (6) tick(); check("sweep_idx2", UpdIdx, 3'd2);
    An = 4'b0111; SSeg = 8'h8E; repeat (6) tick(); check("sweep_idx3", UpdIdx, 3'd3);
    check("sweep_upd",   upd_cnt - upd_base, 4);
    check("sweep_hex",   HexOut, 16'hFA90);
    check("sweep_valid", DigitValid, 4'b1111);
    check("sweep_dp",    DPOut, 4'b0000);

    // Reset in the middle of an Update pulse
    An   = 4'b1110;
    SSeg = 8'hA4;
    repeat (5) tick();
    check("midrst_pulse", Update, 1'b1);
    #1 nRst = 1'b0;
    #1;
    check("midrst_hex",  HexOut, 16'h0000);
    check("midrst_misc", {DPOut, DigitValid, Update, UpdIdx, Err}, 13'h0);
    tick();
    tick();
    nRst = 1'b1;
    repeat (4) tick();
    check("rerun_early", Update, 1'b0);
    tick();
    check("rerun_pulse", Update, 1'b1);
    check("rerun_hex",   HexOut, 16'h0002);
    check("rerun_valid", DigitValid, 4'b0001);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule : tb_seg7_scan_capture
`default_nettype wire
